// File: rtl/priority_mux_core.sv
// N-way priority multiplexer: the lowest-indexed asserted sel bit wins.
// Selection is combinational; dout_q/hit_q give a registered copy.
module priority_mux_core #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT   = 1,
    parameter int unsigned IDX_W = (CNT > 1) ? $clog2(CNT) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH*CNT-1:0] din,
    input  logic [CNT-1:0]       sel,
    output logic [WIDTH-1:0]     dout,
    output logic                 hit,
    output logic [CNT-1:0]       grant,
    output logic [IDX_W-1:0]     grant_idx,
    output logic [WIDTH-1:0]     dout_q,
    output logic                 hit_q
);

    logic found;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        for (int unsigned i = 0; i < CNT; i++) begin
            if (sel[i] && !found) begin
                grant[i]  = 1'b1;
                grant_idx = IDX_W'(i);
                found     = 1'b1;
            end
        end
    end

    // AND-OR masking by the one-hot grant keeps unselected slices (even X) out of dout.
    always_comb begin
        dout = '0;
        for (int unsigned i = 0; i < CNT; i++) begin
            dout = dout | (din[i*WIDTH +: WIDTH] & {WIDTH{grant[i]}});
        end
    end

    assign hit = |sel;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_q <= '0;
            hit_q  <= 1'b0;
        end else begin
            dout_q <= dout;
            hit_q  <= hit;
        end
    end

endmodule

// File: tb/tb_priority_mux_core.sv
// Self-checking bench for priority_mux_core: three configurations checked
// against a lowest-set-bit arithmetic reference model.
module tb_priority_mux_core;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    // WIDTH=4, CNT=3
    logic [11:0] din3;
    logic [2:0]  sel3, grant3;
    logic [3:0]  dout3, doutq3;
    logic [1:0]  gidx3;
    logic        hit3, hitq3;

    // WIDTH=8, CNT=1
    logic [7:0]  din1, dout1, doutq1;
    logic [0:0]  sel1, grant1, gidx1;
    logic        hit1, hitq1;

    // WIDTH=7, CNT=5
    logic [34:0] din5;
    logic [4:0]  sel5, grant5;
    logic [6:0]  dout5, doutq5;
    logic [2:0]  gidx5;
    logic        hit5, hitq5;

    priority_mux_core #(.WIDTH(4), .CNT(3)) u3 (
        .clk(clk), .rst_n(rst_n), .din(din3), .sel(sel3), .dout(dout3), .hit(hit3),
        .grant(grant3), .grant_idx(gidx3), .dout_q(doutq3), .hit_q(hitq3)
    );

    priority_mux_core #(.WIDTH(8), .CNT(1)) u1 (
        .clk(clk), .rst_n(rst_n), .din(din1), .sel(sel1), .dout(dout1), .hit(hit1),
        .grant(grant1), .grant_idx(gidx1), .dout_q(doutq1), .hit_q(hitq1)
    );

    priority_mux_core #(.WIDTH(7), .CNT(5)) u5 (
        .clk(clk), .rst_n(rst_n), .din(din5), .sel(sel5), .dout(dout5), .hit(hit5),
        .grant(grant5), .grant_idx(gidx5), .dout_q(doutq5), .hit_q(hitq5)
    );

    // Reference model: isolate lowest set bit with s & -s, then log2 gives the index.
    function automatic logic [4:0] m_grant5(input logic [4:0] s);
        return s & (~s + 5'd1);
    endfunction

    function automatic int m_idx5(input logic [4:0] s);
        logic [4:0] g;
        g = m_grant5(s);
        return (g == 5'd0) ? 0 : $clog2(g);
    endfunction

    function automatic logic [6:0] m_dout5(input logic [34:0] d, input logic [4:0] s);
        if (s == 5'd0) return 7'd0;
        return 7'(d >> (m_idx5(s) * 7));
    endfunction

    function automatic logic [2:0] m_grant3(input logic [2:0] s);
        return s & (~s + 3'd1);
    endfunction

    function automatic logic [3:0] m_dout3(input logic [11:0] d, input logic [2:0] s);
        logic [2:0] g;
        g = m_grant3(s);
        if (g == 3'd0) return 4'd0;
        return 4'(d >> ($clog2(g) * 4));
    endfunction

    task automatic test_reset();
        din3 = 12'hCBA; sel3 = 3'b010;
        din1 = 8'h5A;   sel1 = 1'b1;
        din5 = '1;      sel5 = 5'b00100;
        rst_n = 1'b0;
        #1;
        total++; if (doutq3 !== 4'h0 || hitq3 !== 1'b0) begin bad++; $display("FAIL reset_u3: dout_q=%h hit_q=%b want 0/0", doutq3, hitq3); end
        total++; if (doutq1 !== 8'h0 || hitq1 !== 1'b0) begin bad++; $display("FAIL reset_u1: dout_q=%h hit_q=%b want 0/0", doutq1, hitq1); end
        total++; if (doutq5 !== 7'h0 || hitq5 !== 1'b0) begin bad++; $display("FAIL reset_u5: dout_q=%h hit_q=%b want 0/0", doutq5, hitq5); end
        total++; if (dout3 !== 4'hB || hit3 !== 1'b1) begin bad++; $display("FAIL reset_comb_live: dout=%h hit=%b want B/1", dout3, hit3); end
        @(posedge clk); #1;
        total++; if (doutq3 !== 4'h0) begin bad++; $display("FAIL reset_hold: dout_q=%h want 0", doutq3); end
        rst_n = 1'b1;
    endtask

    task automatic test_single_request();
        din3 = 12'hCBA; sel3 = 3'b010; #1;
        total++; if (dout3 !== 4'hB || grant3 !== 3'b010 || gidx3 !== 2'd1 || hit3 !== 1'b1) begin
            bad++; $display("FAIL single_sel1: dout=%h grant=%b idx=%0d hit=%b want B/010/1/1", dout3, grant3, gidx3, hit3); end
        sel3 = 3'b100; #1;
        total++; if (dout3 !== 4'hC || grant3 !== 3'b100 || gidx3 !== 2'd2) begin
            bad++; $display("FAIL single_sel2: dout=%h grant=%b idx=%0d want C/100/2", dout3, grant3, gidx3); end
    endtask

    task automatic test_priority();
        din3 = 12'hCBA; sel3 = 3'b111; #1;
        total++; if (dout3 !== 4'hA || grant3 !== 3'b001 || gidx3 !== 2'd0) begin
            bad++; $display("FAIL prio_111: dout=%h grant=%b idx=%0d want A/001/0", dout3, grant3, gidx3); end
        sel3 = 3'b110; #1;
        total++; if (dout3 !== 4'hB || grant3 !== 3'b010 || gidx3 !== 2'd1) begin
            bad++; $display("FAIL prio_110: dout=%h grant=%b idx=%0d want B/010/1", dout3, grant3, gidx3); end
    endtask

    task automatic test_no_request();
        din3 = 12'hFFF; sel3 = 3'b000; #1;
        total++; if (dout3 !== 4'h0 || hit3 !== 1'b0 || grant3 !== 3'b000 || gidx3 !== 2'd0) begin
            bad++; $display("FAIL no_req: dout=%h hit=%b grant=%b idx=%0d want 0/0/0/0", dout3, hit3, grant3, gidx3); end
        din5 = '1; sel5 = 5'b0; #1;
        total++; if (dout5 !== 7'h0 || hit5 !== 1'b0 || grant5 !== 5'b0 || gidx5 !== 3'd0) begin
            bad++; $display("FAIL no_req5: dout=%h hit=%b grant=%b idx=%0d want 0/0/0/0", dout5, hit5, grant5, gidx5); end
    endtask

    task automatic test_cnt1();
        din1 = 8'h5A; sel1 = 1'b1; #1;
        total++; if (dout1 !== 8'h5A || grant1 !== 1'b1 || gidx1 !== 1'b0 || hit1 !== 1'b1) begin
            bad++; $display("FAIL cnt1_sel: dout=%h grant=%b idx=%b hit=%b want 5A/1/0/1", dout1, grant1, gidx1, hit1); end
        sel1 = 1'b0; #1;
        total++; if (dout1 !== 8'h00 || grant1 !== 1'b0 || gidx1 !== 1'b0 || hit1 !== 1'b0) begin
            bad++; $display("FAIL cnt1_nosel: dout=%h grant=%b idx=%b hit=%b want 00/0/0/0", dout1, grant1, gidx1, hit1); end
    endtask

    task automatic test_registered_reset();
        @(posedge clk); #1;
        din3 = {8'hE9, 4'h7}; sel3 = 3'b001; #1;
        total++; if (dout3 !== 4'h7) begin bad++; $display("FAIL reg_comb: dout=%h want 7", dout3); end
        @(posedge clk); #1;
        total++; if (doutq3 !== 4'h7 || hitq3 !== 1'b1) begin
            bad++; $display("FAIL reg_capture: dout_q=%h hit_q=%b want 7/1", doutq3, hitq3); end
        @(negedge clk);
        rst_n = 1'b0; #1;
        total++; if (doutq3 !== 4'h0 || hitq3 !== 1'b0) begin
            bad++; $display("FAIL async_reset: dout_q=%h hit_q=%b want 0/0", doutq3, hitq3); end
        total++; if (dout3 !== 4'h7 || hit3 !== 1'b1) begin
            bad++; $display("FAIL reset_comb_track: dout=%h hit=%b want 7/1", dout3, hit3); end
        #1 rst_n = 1'b1; #1;
        total++; if (doutq3 !== 4'h0) begin bad++; $display("FAIL release_no_capture: dout_q=%h want 0", doutq3); end
        @(posedge clk); #1;
        total++; if (doutq3 !== 4'h7 || hitq3 !== 1'b1) begin
            bad++; $display("FAIL first_capture: dout_q=%h hit_q=%b want 7/1", doutq3, hitq3); end
    endtask

    task automatic test_x_isolation();
        din3 = 12'bxxxx_xxxx_0011; sel3 = 3'b001; #1;
        total++; if (dout3 !== 4'h3) begin bad++; $display("FAIL xiso_0: dout=%b want 0011", dout3); end
        din3 = 12'b0011_xxxx_xxxx; sel3 = 3'b100; #1;
        total++; if (dout3 !== 4'h3) begin bad++; $display("FAIL xiso_2: dout=%b want 0011", dout3); end
        din3 = 12'bxxxx_0011_xxxx; sel3 = 3'b110; #1;
        total++; if (dout3 !== 4'h3) begin bad++; $display("FAIL xiso_1: dout=%b want 0011", dout3); end
    endtask

    task automatic test_random();
        logic [6:0] prev5;
        logic       prevh5;
        logic [3:0] prev3;
        @(posedge clk); #1;
        for (int n = 0; n < 300; n++) begin
            din5 = {$urandom, $urandom};
            sel5 = 5'($urandom);
            if (n % 7 == 0) sel5 = 5'b0;
            din3 = 12'($urandom);
            sel3 = 3'($urandom);
            #1;
            total++; if (dout5 !== m_dout5(din5, sel5) || grant5 !== m_grant5(sel5) ||
                         int'(gidx5) != m_idx5(sel5) || hit5 !== (sel5 != 5'b0)) begin
                bad++; $display("FAIL rand5 sel=%b: dout=%h grant=%b idx=%0d hit=%b want %h/%b/%0d/%b",
                                sel5, dout5, grant5, gidx5, hit5, m_dout5(din5, sel5), m_grant5(sel5),
                                m_idx5(sel5), sel5 != 5'b0); end
            total++; if (dout3 !== m_dout3(din3, sel3) || grant3 !== m_grant3(sel3)) begin
                bad++; $display("FAIL rand3 sel=%b: dout=%h grant=%b want %h/%b",
                                sel3, dout3, grant3, m_dout3(din3, sel3), m_grant3(sel3)); end
            prev5  = m_dout5(din5, sel5);
            prevh5 = (sel5 != 5'b0);
            prev3  = m_dout3(din3, sel3);
            @(posedge clk); #1;
            total++; if (doutq5 !== prev5 || hitq5 !== prevh5 || doutq3 !== prev3) begin
                bad++; $display("FAIL rand_reg: dout_q5=%h hit_q5=%b dout_q3=%h want %h/%b/%h",
                                doutq5, hitq5, doutq3, prev5, prevh5, prev3); end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_request();
        test_priority();
        test_no_request();
        test_cnt1();
        test_registered_reset();
        test_x_isolation();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
